// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing one ALU_nbit between NREQ requesters, with
// registered operands before the ALU and a registered result after it.
module alu_rr_arbiter #(
    parameter int n    = 4,
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*n-1:0] req_a,
    input  logic [NREQ*n-1:0] req_b,
    input  logic [NREQ*3-1:0] req_sel,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [n-1:0]      rsp_o,
    output logic              rsp_co,
    output logic              busy,
    output logic [1:0]        dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid && ready.
    // Requesters hold valid and payload until ready; rsp_* hold until rsp_ready.
    typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

    state_t         state, state_nxt;
    logic [IDW-1:0] rr_ptr, rr_ptr_nxt;
    logic [IDW-1:0] win_id, cand;
    logic [IDW:0]   sum;
    logic           win_found;
    logic [n-1:0]   op_a, op_b;
    logic [2:0]     op_sel;
    logic [IDW-1:0] op_id;
    logic [n-1:0]   alu_o;
    logic           alu_co;

    // First valid requester at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        sum       = '0;
        cand      = '0;
        for (int k = 0; k < NREQ; k++) begin
            sum = {1'b0, rr_ptr} + k[IDW:0];
            if (sum >= (IDW+1)'(NREQ))
                sum = sum - (IDW+1)'(NREQ);
            cand = sum[IDW-1:0];
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE && win_found && !rst)
            req_ready[win_id] = 1'b1;
    end

    assign rr_ptr_nxt = (win_id == IDW'(NREQ-1)) ? '0 : win_id + 1'b1;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (win_found) state_nxt = EXEC;
            EXEC:    state_nxt = RESP;
            RESP:    if (rsp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            op_a      <= '0;
            op_b      <= '0;
            op_sel    <= '0;
            op_id     <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_o     <= '0;
            rsp_co    <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (win_found) begin
                        op_a   <= req_a[win_id*n +: n];
                        op_b   <= req_b[win_id*n +: n];
                        op_sel <= req_sel[win_id*3 +: 3];
                        op_id  <= win_id;
                        rr_ptr <= rr_ptr_nxt;
                    end
                end
                EXEC: begin
                    rsp_o     <= alu_o;
                    rsp_co    <= alu_co;
                    rsp_id    <= op_id;
                    rsp_valid <= 1'b1;
                end
                RESP: begin
                    if (rsp_ready) rsp_valid <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign dbg_state = state;

    ALU_nbit #(.n(n)) u_alu (
        .a   (op_a),
        .b   (op_b),
        .sel (op_sel),
        .o   (alu_o),
        .co  (alu_co)
    );

endmodule

// Combinational n-bit ALU; co is carry for add, borrow for subtract and the
// shifted-out bit for shifts, zero for logic ops.
module ALU_nbit #(
    parameter int n = 4
) (
    input  logic [n-1:0] a,
    input  logic [n-1:0] b,
    input  logic [2:0]   sel,
    output logic [n-1:0] o,
    output logic         co
);

    logic [n:0] res;

    always_comb begin
        res = '0;
        case (sel)
            3'd0:    res = {1'b0, a} + {1'b0, b};
            3'd1:    res = {1'b0, a} - {1'b0, b};
            3'd2:    res = {1'b0, a & b};
            3'd3:    res = {1'b0, a | b};
            3'd4:    res = {1'b0, a ^ b};
            3'd5:    res = {1'b0, ~a};
            3'd6:    res = {a, 1'b0};
            default: res = {a[0], 1'b0, a[n-1:1]};
        endcase
    end

    assign o  = res[n-1:0];
    assign co = res[n];

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Directed bench for alu_rr_arbiter: reset, grant order, backpressure,
// payload sampling, mid-operation reset and an exhaustive ALU sweep.
module tb_alu_rr_arbiter;

    localparam int N    = 4;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*N-1:0] req_a;
    logic [NREQ*N-1:0] req_b;
    logic [NREQ*3-1:0] req_sel;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [IDW-1:0]    rsp_id;
    logic [N-1:0]      rsp_o;
    logic              rsp_co;
    logic              busy;
    logic [1:0]        dbg_state;

    int checks = 0;
    int errors = 0;

    alu_rr_arbiter #(.n(N), .NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_sel   (req_sel),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_o     (rsp_o),
        .rsp_co    (rsp_co),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // Independent reference: {co, o}
    function automatic logic [N:0] alu_model(input logic [N-1:0] a, input logic [N-1:0] b,
                                             input logic [2:0] sel);
        int s;
        case (sel)
            3'd0: begin s = int'(a) + int'(b); return {s >= 16, 4'(s)}; end
            3'd1: return {a < b, 4'(a - b)};
            3'd2: return {1'b0, a & b};
            3'd3: return {1'b0, a | b};
            3'd4: return {1'b0, a ^ b};
            3'd5: return {1'b0, ~a};
            3'd6: return {a[3], a[2:0], 1'b0};
            default: return {a[0], 1'b0, a[3:1]};
        endcase
    endfunction

    task automatic set_req(input int i, input logic [N-1:0] a, input logic [N-1:0] b,
                           input logic [2:0] sel);
        req_a[i*N +: N] = a;
        req_b[i*N +: N] = b;
        req_sel[i*3 +: 3] = sel;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        tick();
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready got %b want 0000", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if ({rsp_id, rsp_co, rsp_o} !== 7'd0) begin errors++; $display("FAIL reset_rsp_fields got id=%0d co=%b o=%0d want 0", rsp_id, rsp_co, rsp_o); end
        checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", dbg_state); end
        req_valid = '0;
        tick();
        rst = 1'b0;
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy got %b want 0", busy); end
    endtask

    task automatic test_single();
        rsp_ready = 1'b1;
        set_req(2, 4'd9, 4'd7, 3'd0);
        req_sel[2:0] = 3'bxxx;
        req_valid = 4'b0100;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_grant got %b want 0100", req_ready); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_T got %b want 0", busy); end
        tick();
        req_valid = '0;
        req_sel[2:0] = 3'd0;
        #1;
        checks++; if (busy !== 1'b1 || rsp_valid !== 1'b0 || req_ready !== 4'b0000) begin errors++; $display("FAIL single_T1 got busy=%b rsp_valid=%b ready=%b want 1 0 0000", busy, rsp_valid, req_ready); end
        tick();
        checks++; if (rsp_valid !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL single_T2_valid got rsp_valid=%b busy=%b want 1 1", rsp_valid, busy); end
        checks++; if (rsp_id !== 2'd2 || rsp_o !== 4'd0 || rsp_co !== 1'b1) begin errors++; $display("FAIL single_result got id=%0d o=%0d co=%b want 2 0 1", rsp_id, rsp_o, rsp_co); end
        tick();
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL single_T3 got rsp_valid=%b busy=%b want 0 0", rsp_valid, busy); end
    endtask

    task automatic test_round_robin();
        int exp_id[5] = '{0, 1, 2, 3, 0};
        logic [N:0] exp_res[5] = '{5'd3, 5'd3, 5'd8, 5'd12, 5'd3};
        int gid[5];
        int gcyc[5];
        int ngrant = 0;
        int nrsp = 0;
        int cyc = 0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_req(0, 4'd1, 4'd2, 3'd0);
        set_req(1, 4'd6, 4'd3, 3'd1);
        set_req(2, 4'd12, 4'd10, 3'd2);
        set_req(3, 4'd5, 4'd9, 3'd4);
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        while (nrsp < 5 && cyc < 40) begin
            if (ngrant >= 5) req_valid = '0;
            #1;
            if (req_ready !== 4'b0000 && ngrant < 5) begin
                gid[ngrant] = -1;
                for (int i = 0; i < NREQ; i++) if (req_ready[i]) gid[ngrant] = i;
                gcyc[ngrant] = cyc;
                ngrant++;
            end
            if (rsp_valid === 1'b1) begin
                checks++;
                if (int'(rsp_id) != exp_id[nrsp] || {rsp_co, rsp_o} !== exp_res[nrsp]) begin
                    errors++;
                    $display("FAIL rr_rsp%0d got id=%0d res=%h want id=%0d res=%h", nrsp, rsp_id, {rsp_co, rsp_o}, exp_id[nrsp], exp_res[nrsp]);
                end
                nrsp++;
            end
            tick();
            cyc++;
        end
        checks++; if (ngrant != 5 || nrsp != 5) begin errors++; $display("FAIL rr_count got grants=%0d rsps=%0d want 5 5", ngrant, nrsp); end
        for (int g = 0; g < ngrant; g++) begin
            checks++;
            if (gid[g] != exp_id[g] || gcyc[g] != 3 * g) begin
                errors++;
                $display("FAIL rr_grant%0d got id=%0d cyc=%0d want id=%0d cyc=%0d", g, gid[g], gcyc[g], exp_id[g], 3 * g);
            end
        end
        req_valid = '0;
    endtask

    task automatic test_backpressure();
        rsp_ready = 1'b0;
        set_req(0, 4'd2, 4'd3, 3'd3);
        req_valid = 4'b0001;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL bp_grant got %b want 0001", req_ready); end
        tick();
        set_req(1, 4'd7, 4'd7, 3'd0);
        req_valid = 4'b0010;
        #1;
        checks++; if (req_ready !== 4'b0000) begin errors++; $display("FAIL bp_exec_ready got %b want 0000", req_ready); end
        tick();
        for (int k = 0; k < 5; k++) begin
            checks++;
            if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_o !== 4'd3 || rsp_co !== 1'b0 || req_ready !== 4'b0000) begin
                errors++;
                $display("FAIL bp_hold%0d got valid=%b id=%0d o=%0d co=%b ready=%b want 1 0 3 0 0000", k, rsp_valid, rsp_id, rsp_o, rsp_co, req_ready);
            end
            tick();
        end
        rsp_ready = 1'b1;
        #1;
        checks++; if (req_ready !== 4'b0000 || rsp_valid !== 1'b1) begin errors++; $display("FAIL bp_no_bypass got ready=%b valid=%b want 0000 1", req_ready, rsp_valid); end
        tick();
        checks++; if (rsp_valid !== 1'b0 || req_ready !== 4'b0010) begin errors++; $display("FAIL bp_release got valid=%b ready=%b want 0 0010", rsp_valid, req_ready); end
        tick();
        req_valid = '0;
        tick();
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_o !== 4'd14 || rsp_co !== 1'b0) begin errors++; $display("FAIL bp_second got valid=%b id=%0d o=%0d co=%b want 1 1 14 0", rsp_valid, rsp_id, rsp_o, rsp_co); end
        tick();
    endtask

    task automatic test_payload_change();
        rsp_ready = 1'b1;
        set_req(1, 4'd3, 4'd5, 3'd1);
        req_valid = 4'b0010;
        #1;
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL payload_grant got %b want 0010", req_ready); end
        tick();
        req_valid = '0;
        set_req(1, 4'd15, 4'd5, 3'd1);
        tick();
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_o !== 4'd14 || rsp_co !== 1'b1) begin errors++; $display("FAIL payload_result got valid=%b id=%0d o=%0d co=%b want 1 1 14 1", rsp_valid, rsp_id, rsp_o, rsp_co); end
        tick();
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        set_req(2, 4'd4, 4'd4, 3'd0);
        req_valid = 4'b0100;
        #1;
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL rmid_grant got %b want 0100", req_ready); end
        tick();
        req_valid = '0;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL rmid_exec_busy got %b want 1", busy); end
        rst = 1'b1;
        #1;
        checks++; if (rsp_valid !== 1'b0 || busy !== 1'b0 || dbg_state !== 2'd0) begin errors++; $display("FAIL rmid_async got valid=%b busy=%b state=%0d want 0 0 0", rsp_valid, busy, dbg_state); end
        checks++; if (rsp_o !== 4'd0 || rsp_co !== 1'b0 || rsp_id !== 2'd0) begin errors++; $display("FAIL rmid_fields got o=%0d co=%b id=%0d want 0 0 0", rsp_o, rsp_co, rsp_id); end
        tick();
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            if (rsp_valid !== 1'b0) seen++;
            tick();
        end
        checks++; if (seen != 0) begin errors++; $display("FAIL rmid_no_rsp got %0d valid cycles want 0", seen); end
        set_req(0, 4'd1, 4'd1, 3'd0);
        set_req(1, 4'd2, 4'd2, 3'd0);
        set_req(3, 4'd3, 4'd3, 3'd0);
        req_valid = 4'b1111;
        #1;
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rmid_ptr got %b want 0001", req_ready); end
        tick();
        req_valid = '0;
        tick();
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_o !== 4'd2 || rsp_co !== 1'b0) begin errors++; $display("FAIL rmid_after got valid=%b id=%0d o=%0d co=%b want 1 0 2 0", rsp_valid, rsp_id, rsp_o, rsp_co); end
        tick();
    endtask

    task automatic test_sweep();
        logic [N:0] exp;
        rsp_ready = 1'b1;
        for (int s = 0; s < 8; s++) begin
            for (int a = 0; a < 16; a++) begin
                for (int b = 0; b < 16; b++) begin
                    set_req(3, 4'(a), 4'(b), 3'(s));
                    req_valid = 4'b1000;
                    #1;
                    checks++;
                    if (req_ready !== 4'b1000) begin errors++; $display("FAIL sweep_grant s=%0d a=%0d b=%0d got %b want 1000", s, a, b, req_ready); end
                    tick();
                    req_valid = '0;
                    tick();
                    exp = alu_model(4'(a), 4'(b), 3'(s));
                    checks++;
                    if (rsp_valid !== 1'b1 || rsp_id !== 2'd3 || {rsp_co, rsp_o} !== exp) begin
                        errors++;
                        $display("FAIL sweep s=%0d a=%0d b=%0d got valid=%b id=%0d co=%b o=%0d want 1 3 %b %0d", s, a, b, rsp_valid, rsp_id, rsp_co, rsp_o, exp[N], exp[N-1:0]);
                    end
                    tick();
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        req_sel = '0;
        rsp_ready = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_payload_change();
        test_reset_mid();
        test_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
